// File: rtl/arb_tree_bridge_rr_lock.sv
// N-to-1 round-robin request arbiter with bounded per-master lock and an
// optional single-slot registered output stage between masters and one slave port.
module arb_tree_bridge_rr_lock #(
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 20,
  parameter int N_MASTER   = 16,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int AUX_WIDTH  = 6,
  parameter int MAX_LOCK   = 8,
  parameter int OUT_REG    = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_MASTER-1:0]              data_req_i,
  input  logic [N_MASTER*ADDR_WIDTH-1:0]   data_add_i,
  input  logic [N_MASTER-1:0]              data_wen_i,
  input  logic [N_MASTER*DATA_WIDTH-1:0]   data_wdata_i,
  input  logic [N_MASTER*BE_WIDTH-1:0]     data_be_i,
  input  logic [N_MASTER*ID_WIDTH-1:0]     data_ID_i,
  input  logic [N_MASTER*AUX_WIDTH-1:0]    data_aux_i,
  input  logic [N_MASTER-1:0]              data_lock_i,
  output logic [N_MASTER-1:0]              data_gnt_o,
  output logic                             data_req_o,
  output logic [ADDR_WIDTH-1:0]            data_add_o,
  output logic                             data_wen_o,
  output logic [DATA_WIDTH-1:0]            data_wdata_o,
  output logic [BE_WIDTH-1:0]              data_be_o,
  output logic [ID_WIDTH-1:0]              data_ID_o,
  output logic [AUX_WIDTH-1:0]             data_aux_o,
  input  logic                             data_gnt_i
);

  localparam int IDX_W = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;
  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  localparam int PAY_W = ADDR_WIDTH + 1 + DATA_WIDTH + BE_WIDTH + ID_WIDTH + AUX_WIDTH;
  localparam logic [IDX_W-1:0] RR_RST  = IDX_W'(N_MASTER - 1);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(MAX_LOCK - 1);

  logic [IDX_W-1:0]    r_rr;
  logic                r_lock;
  logic [IDX_W-1:0]    r_owner;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_valid;
  logic [PAY_W-1:0]    r_pay;

  logic [N_MASTER-1:0] w_elig;
  logic [N_MASTER-1:0] w_sel_oh;
  logic [IDX_W-1:0]    w_sel_hi;
  logic [IDX_W-1:0]    w_sel_lo;
  logic [IDX_W-1:0]    w_sel;
  logic                w_any_hi;
  logic                w_any;
  logic                w_lock_sel;
  logic [PAY_W-1:0]    w_pay;
  logic [PAY_W-1:0]    w_out_pay;
  logic                w_slot_free;
  logic                w_fire;
  logic                w_acc;

  // Eligibility: a held lock masks every requester except the owner.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < N_MASTER; i++) begin
      w_elig[i] = data_req_i[i] && (!r_lock || (r_owner == IDX_W'(i)));
    end
  end

  // Round-robin pick: lowest eligible index above the last winner, else lowest overall.
  always_comb begin
    w_sel_hi = '0;
    w_sel_lo = '0;
    w_any_hi = 1'b0;
    for (int i = N_MASTER - 1; i >= 0; i--) begin
      w_sel_lo = w_elig[i] ? IDX_W'(i) : w_sel_lo;
      w_sel_hi = (w_elig[i] && (IDX_W'(i) > r_rr)) ? IDX_W'(i) : w_sel_hi;
      w_any_hi = w_any_hi | (w_elig[i] && (IDX_W'(i) > r_rr));
    end
    w_any = |w_elig;
    w_sel = w_any_hi ? w_sel_hi : w_sel_lo;
  end

  // Payload, lock flag and one-hot of the selected master.
  always_comb begin
    w_pay      = '0;
    w_lock_sel = 1'b0;
    w_sel_oh   = '0;
    for (int i = 0; i < N_MASTER; i++) begin
      w_sel_oh[i] = w_any && (w_sel == IDX_W'(i));
      w_lock_sel  = w_sel_oh[i] ? data_lock_i[i] : w_lock_sel;
      w_pay       = w_sel_oh[i] ? {data_add_i[i*ADDR_WIDTH +: ADDR_WIDTH], data_wen_i[i],
                                   data_wdata_i[i*DATA_WIDTH +: DATA_WIDTH],
                                   data_be_i[i*BE_WIDTH +: BE_WIDTH],
                                   data_ID_i[i*ID_WIDTH +: ID_WIDTH],
                                   data_aux_i[i*AUX_WIDTH +: AUX_WIDTH]} : w_pay;
    end
  end

  assign w_slot_free = !r_valid || data_gnt_i;
  assign w_fire      = (OUT_REG != 0) ? w_slot_free : data_gnt_i;
  assign w_acc       = w_any && w_fire;
  assign data_gnt_o  = w_fire ? w_sel_oh : '0;

  // Output select: slot contents when registered, live selection otherwise.
  always_comb begin
    if (OUT_REG != 0) begin
      data_req_o = r_valid;
      w_out_pay  = r_valid ? r_pay : '0;
    end else begin
      data_req_o = w_any;
      w_out_pay  = w_pay;
    end
  end

  assign {data_add_o, data_wen_o, data_wdata_o, data_be_o, data_ID_o, data_aux_o} = w_out_pay;

  // Arbitration state: pointer and lock bookkeeping move only on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr    <= RR_RST;
      r_lock  <= 1'b0;
      r_owner <= '0;
      r_cnt   <= '0;
    end else if (w_acc) begin
      r_rr <= w_sel;
      if (w_lock_sel && (r_cnt < CNT_LIM)) begin
        r_lock  <= 1'b1;
        r_owner <= w_sel;
        r_cnt   <= r_cnt + CNT_W'(1);
      end else begin
        r_lock <= 1'b0;
        r_cnt  <= '0;
      end
    end
  end

  // Output slot: reload on accept (also when popped the same cycle), else drain on grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_pay   <= '0;
    end else if ((OUT_REG != 0) && w_acc) begin
      r_valid <= 1'b1;
      r_pay   <= w_pay;
    end else if ((OUT_REG != 0) && r_valid && data_gnt_i) begin
      r_valid <= 1'b0;
    end
  end

endmodule
